uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- UART receive path: oversamples the asynchronous `rx_pin` and validates the start bit at mid-bit.
- Shifts in DATA_WIDTH bits LSB-first, then checks the stop bit(s).
- Presents each good byte on a valid/ready output handshake.
- Pairs with the transmitter at the far end of the serial link; sits between the pad and the consuming logic (FIFO or register file).

Parameters:
- DATA_WIDTH, 8: data bits per frame (5..9).
- STOP_BITS, 1: stop bits checked per frame (1 or 2).
- CLKS_PER_BIT, 16: clk cycles per serial bit; minimum 4. HALF = CLKS_PER_BIT/2 (integer division).
- PARITY_ODD, 0: 1 = odd parity, 0 = even. Used only when UART_RX_PARITY_EN is defined.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_pin  input  1  serial line; idle high; asynchronous to clk.
- rx_data  output  DATA_WIDTH  received word; stable while rx_valid=1.
- rx_valid  output  1  rx_data holds an unconsumed word.
- rx_ready  input  1  consumer accepts; a transfer occurs when rx_valid & rx_ready.
- frame_err  output  1  1-cycle pulse: a stop-bit sample was 0.
- overrun_err  output  1  1-cycle pulse: a good frame was dropped because the output was still full.
- parity_err  output  1  1-cycle pulse on parity mismatch; constant 0 without the macro.

Behaviour:
- Reset values:
  - rx_data=0, rx_valid=0, all error outputs 0, state IDLE, counters 0.
  - Synchronizer flops reset to 1, so reset never produces a false start.
- Reset asserted mid-frame aborts the frame immediately; the partial word is discarded.
- rx_pin passes through a 2-flop synchronizer; rx_s is the synchronized value. All sampling uses rx_s.
- clk_cnt width is clog2(CLKS_PER_BIT). bit_cnt width is 4 bits; it wraps only by explicit clear.
- State machine (2-bit encoding, plus PARITY under the macro):
  - IDLE: when rx_s=0 (falling edge), clear clk_cnt and go to START.
  - START: count to HALF-1, then sample rx_s.
    - rx_s=0: go to DATA with clk_cnt=0, bit_cnt=0.
    - rx_s=1: glitch. Return to IDLE with no error pulse.
  - DATA: every CLKS_PER_BIT clks (mid-bit), shift rx_s into the MSB of the shift register (LSB-first line order).
    - After DATA_WIDTH samples, go to STOP (or PARITY if enabled).
  - STOP: every CLKS_PER_BIT clks, sample rx_s.
    - A sample of 0 marks the frame bad and pulses frame_err.
    - After STOP_BITS samples, go to IDLE at mid-stop-bit, so a back-to-back start bit is caught.
- Output register:
  - A good frame is loaded into rx_data, and rx_valid is set, the cycle after the final stop sample.
  - rx_valid & rx_ready with no load in the same cycle: rx_valid clears next cycle.
  - Load while rx_valid=1 and rx_ready=1 in the same cycle: the old word transfers, the new word loads, rx_valid stays 1.
  - Load while rx_valid=1 and rx_ready=0: the new word is dropped, the old word is kept, overrun_err pulses.
  - Bad frames (framing or parity error) never load and never cause overrun_err.
- Latency: from the rx_pin falling edge to rx_valid rising is 2 (sync) + HALF + (DATA_WIDTH+STOP_BITS)*CLKS_PER_BIT + 1 clks, ±1 for edge phase. For defaults that is 155.
- rx_pin activity while rx_valid=1 is still received; rx_ready never back-pressures the line.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state between DATA and STOP samples one parity bit at mid-bit.
  - Expected parity = XOR of the data bits, XOR PARITY_ODD.
  - Mismatch: parity_err pulses at the stop sample, and the frame is discarded (still walks STOP).
  - Frame length grows by CLKS_PER_BIT; latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state, no parity logic, parity_err tied 0.

Decomposition:
- Package uart_pkg holds:
  - state encodings IDLE/START/DATA/STOP/PARITY, shared with the transmitter;
  - the LINE_IDLE=1, START_BIT=0 and STOP_BIT=1 constants;
  - a clog2 helper for the counter width.
- Sub-module uart_rx_sync: 2-flop synchronizer with async reset-to-1. It outputs rx_s and a 1-cycle fall pulse.
- The FSM, counters, shift register and output register stay in uart_receiver.

Test Plan:
- Defaults, send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) at 16 clks/bit, rx_ready=1 → rx_data=0xA5, rx_valid high 1 cycle at 155±1 clks after the edge, no errors.
- Send 0x3C then 0xC3 back-to-back (0 idle bits), rx_ready=0 until after the second frame → rx_data=0x3C held, overrun_err pulses once, then 0x3C transfers on rx_ready.
- Stop bit driven 0 on 0x55 → frame_err 1-cycle pulse, rx_valid stays 0; the next good frame 0x12 is received correctly.
- rx_pin low pulse of 4 clks in IDLE → no rx_valid, no errors, FSM back in IDLE by HALF+3 clks.
- Assert reset at data bit 4 of frame 0xFF, release, then send 0x81 → only 0x81 appears; rx_valid=0 during and after reset.
- UART_RX_PARITY_EN, PARITY_ODD=0: 0x07 with parity 1 → accepted; same with parity 0 → parity_err pulse, no rx_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, line-level constants, counter width helper.
// Defining UART_RX_PARITY_EN widens the state type to hold the PARITY state.
package uart_pkg;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } uart_state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;
`endif

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Bits needed to hold the values 0 .. value-1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial input with reset-to-idle, plus a falling-edge pulse.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic rx_i,
  output logic rx_s_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Reset to the idle level so leaving reset can never look like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= LINE_IDLE;
      sync_q <= LINE_IDLE;
      prev_q <= LINE_IDLE;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_s_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: mid-bit sampling FSM, LSB-first shift register and valid/ready output.
// Optional parity checking is compiled in when UART_RX_PARITY_EN is defined.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_pin,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  frame_err,
  output logic                  overrun_err,
  output logic                  parity_err
);

  localparam int unsigned CntW = clog2(CLKS_PER_BIT);
  localparam int unsigned Half = CLKS_PER_BIT / 2;

  localparam logic [CntW-1:0] HalfLast = CntW'(Half - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      DataLast = 4'(DATA_WIDTH - 1);
  localparam logic [3:0]      StopLast = 4'(STOP_BITS - 1);

  logic rx_s;
  logic rx_fall;

  uart_rx_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .rx_i   (rx_pin),
    .rx_s_o (rx_s),
    .fall_o (rx_fall)
  );

  uart_state_e           state_q, state_d;
  logic [CntW-1:0]       clk_cnt_q, clk_cnt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  bad_q, bad_d;
  logic                  frame_err_q, frame_err_d;
  logic                  parity_err_q, parity_err_d;
  logic                  load;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic par_bad;

  assign par_bad = par_q != ((^shift_q) ^ PARITY_ODD);
`else
  logic unused_parity_odd;

  assign unused_parity_odd = PARITY_ODD;
`endif

  // Frame FSM: all sampling happens at the midpoint of each bit.
  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q + 1'b1;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    bad_d        = bad_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    load         = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (rx_fall) begin
          state_d = START;
        end
      end
      START: begin
        if (clk_cnt_q == HalfLast) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          bad_d     = 1'b0;
          // A line that is high again at mid-start was a glitch.
          state_d   = (rx_s == START_BIT) ? DATA : IDLE;
        end
      end
      DATA: begin
        if (clk_cnt_q == BitLast) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[DATA_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == DataLast) begin
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_cnt_q == BitLast) begin
          clk_cnt_d = '0;
          par_d     = rx_s;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (clk_cnt_q == BitLast) begin
          clk_cnt_d = '0;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (rx_s != STOP_BIT) begin
            frame_err_d = 1'b1;
            bad_d       = 1'b1;
          end
          if (bit_cnt_q == StopLast) begin
            // Leave at mid-stop so a back-to-back start edge is not missed.
            state_d   = IDLE;
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            parity_err_d = par_bad;
            load         = (rx_s == STOP_BIT) && !bad_q && !par_bad;
`else
            load         = (rx_s == STOP_BIT) && !bad_q;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      bad_q        <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      bad_q        <= bad_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  // Output holding register with valid/ready handshake.
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  overrun_q, overrun_d;

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    if (load) begin
      if (rx_valid_q && !rx_ready) begin
        overrun_d = 1'b1;
      end else begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`else
  assign parity_err  = 1'b0;
  logic unused_parity_err;
  assign unused_parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: clean frame, overrun, framing error, glitch, mid-frame reset.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int ExpLat = 155 + CPB;
`else
  localparam int ExpLat = 155;
`endif

  logic       clk;
  logic       reset;
  logic       rx_pin;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun_err;
  logic       parity_err;

  uart_receiver #(
    .DATA_WIDTH   (8),
    .STOP_BITS    (1),
    .CLKS_PER_BIT (CPB),
    .PARITY_ODD   (1'b0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_pin      (rx_pin),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled away from the active edge.
  int         fe_n = 0, ov_n = 0, pe_n = 0, vc_n = 0, rise_cyc = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] xfer_q[$];

  always @(negedge clk) begin
    if (frame_err)   fe_n <= fe_n + 1;
    if (overrun_err) ov_n <= ov_n + 1;
    if (parity_err)  pe_n <= pe_n + 1;
    if (rx_valid)    vc_n <= vc_n + 1;
    if (rx_valid && !valid_prev) rise_cyc <= cyc;
    valid_prev <= rx_valid;
    if (rx_valid && rx_ready) xfer_q.push_back(rx_data);
  end

  int n_checks = 0;
  int n_errors = 0;
  int base_fe, base_ov, base_pe, base_vc, base_x;
  int edge_cyc = 0;
  int lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    base_fe = fe_n;
    base_ov = ov_n;
    base_pe = pe_n;
    base_vc = vc_n;
    base_x  = xfer_q.size();
  endtask

  task automatic drive_bit(input logic v);
    rx_pin = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_v, input int idle_bits);
    edge_cyc = cyc;
    drive_bit(START_BIT);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^data);
`endif
    drive_bit(stop_v);
    repeat (idle_bits) drive_bit(LINE_IDLE);
  endtask

  initial begin
    reset    = 1'b1;
    rx_pin   = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(rx_valid), 0);
    check("rst_data", 32'(rx_data), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_overrun", 32'(overrun_err), 0);
    check("rst_parity", 32'(parity_err), 0);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Clean frame with the consumer always ready.
    rx_ready = 1'b1;
    snap();
    send_frame(8'hA5, 1'b1, 1);
    check("a5_count", 32'(xfer_q.size() - base_x), 1);
    check("a5_data", 32'(xfer_q[base_x]), 32'h A5);
    lat = rise_cyc - edge_cyc;
    check("a5_latency_in_window", 32'(lat >= ExpLat - 1 && lat <= ExpLat + 1), 1);
    check("a5_valid_cycles", 32'(vc_n - base_vc), 1);
    check("a5_errors", 32'((fe_n - base_fe) + (ov_n - base_ov) + (pe_n - base_pe)), 0);

    // Back-to-back frames with the consumer stalled: second frame overruns.
    rx_ready = 1'b0;
    snap();
    send_frame(8'h3C, 1'b1, 0);
    send_frame(8'hC3, 1'b1, 1);
    check("ovr_valid_held", 32'(rx_valid), 1);
    check("ovr_data_held", 32'(rx_data), 32'h3C);
    check("ovr_pulses", 32'(ov_n - base_ov), 1);
    check("ovr_frame_err", 32'(fe_n - base_fe), 0);
    check("ovr_no_xfer_yet", 32'(xfer_q.size() - base_x), 0);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    check("ovr_xfer_count", 32'(xfer_q.size() - base_x), 1);
    check("ovr_xfer_data", 32'(xfer_q[base_x]), 32'h3C);
    check("ovr_valid_cleared", 32'(rx_valid), 0);

    // Bad stop bit, then a good frame.
    rx_ready = 1'b1;
    snap();
    send_frame(8'h55, 1'b0, 1);
    check("fe_pulses", 32'(fe_n - base_fe), 1);
    check("fe_no_valid", 32'(vc_n - base_vc), 0);
    check("fe_no_overrun", 32'(ov_n - base_ov), 0);
    snap();
    send_frame(8'h12, 1'b1, 1);
    check("after_fe_count", 32'(xfer_q.size() - base_x), 1);
    check("after_fe_data", 32'(xfer_q[base_x]), 32'h12);
    check("after_fe_no_err", 32'(fe_n - base_fe), 0);

    // Four-clock low glitch while idle.
    snap();
    rx_pin = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx_pin = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("glitch_state_idle", 32'(dut.state_q), 32'(IDLE));
    repeat (200) @(posedge clk);
    #1;
    check("glitch_no_valid", 32'(vc_n - base_vc), 0);
    check("glitch_no_errors", 32'((fe_n - base_fe) + (ov_n - base_ov) + (pe_n - base_pe)), 0);

    // Reset in the middle of data bit 4 of 0xFF.
    snap();
    drive_bit(START_BIT);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx_pin = 1'b1;
    repeat (CPB / 2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid_valid", 32'(rx_valid), 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    check("rst_after_valid", 32'(rx_valid), 0);
    check("rst_no_frame", 32'(vc_n - base_vc), 0);
    snap();
    send_frame(8'h81, 1'b1, 1);
    check("after_rst_count", 32'(xfer_q.size() - base_x), 1);
    check("after_rst_data", 32'(xfer_q[base_x]), 32'h81);

`ifdef UART_RX_PARITY_EN
    snap();
    send_frame(8'h07, 1'b1, 1);
    check("par_ok_count", 32'(xfer_q.size() - base_x), 1);
    check("par_ok_data", 32'(xfer_q[base_x]), 32'h07);
    check("par_ok_no_err", 32'(pe_n - base_pe), 0);
    snap();
    drive_bit(START_BIT);
    for (int i = 0; i < 8; i++) drive_bit(i < 3);
    drive_bit(1'b0);
    drive_bit(STOP_BIT);
    drive_bit(LINE_IDLE);
    check("par_bad_pulse", 32'(pe_n - base_pe), 1);
    check("par_bad_no_valid", 32'(vc_n - base_vc), 0);
`else
    check("parity_never", 32'(pe_n), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
